// File: rtl/id_stage_pkg.sv
// Shared ISA encodings and the decoded-bundle type for the IF->EX decode stage.
// Instruction layout: [15:13]class [12:11]func [10:8]rd [7:5]rs0 [4:2]rs1 [1:0]sub.
package id_stage_pkg;

  localparam logic [2:0] CLS_ALU_CAL     = 3'b000;
  localparam logic [2:0] CLS_ALU_IMM     = 3'b001;
  localparam logic [2:0] CLS_BRANCH      = 3'b010;
  localparam logic [2:0] CLS_BRANCH_JUMP = 3'b011;
  localparam logic [2:0] CLS_DM_FUN      = 3'b100;

  localparam logic [1:0] FUNC_LD            = 2'b00;
  localparam logic [1:0] FUNC_SD            = 2'b01;
  localparam logic [1:0] FUNC_BIN_SHIFT     = 2'b10;
  localparam logic [1:0] FUNC_BIN_SHIFT_IMM = 2'b11;

  typedef struct packed {
    logic [2:0] addr_0;
    logic [2:0] addr_1;
    logic [2:0] w_addr;
    logic [6:0] alu_op;
    logic       branch;
    logic       mem2reg;
    logic       alusrc;
    logic       rf_w_en;
    logic       dm_w_en;
    logic       dm_r_en;
    logic       is_jal;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/id_stage_decode.sv
// Purely combinational instruction decoder: 16-bit word -> register addresses,
// extended immediate, ALU op and control enables. Illegal words decode to all zeros.
module id_stage_decode
  import id_stage_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [15:0]       inst,
  output dec_t              dec,
  output logic [DATA_W-1:0] imm
);

  logic [2:0] cls;
  logic [1:0] func;
  logic [2:0] rd;
  logic [2:0] rs0;
  logic [2:0] rs1;
  logic [1:0] sub;

  logic is_cal;
  logic is_alu_imm;
  logic is_br;
  logic is_jal;
  logic is_ld;
  logic is_sd;
  logic is_shift_imm;
  logic legal;

  assign cls  = inst[15:13];
  assign func = inst[12:11];
  assign rd   = inst[10:8];
  assign rs0  = inst[7:5];
  assign rs1  = inst[4:2];
  assign sub  = inst[1:0];

  // Shift funcs have no sub=10 variant, and sub=11 is unused for every ALU func.
  assign is_cal       = (cls == CLS_ALU_CAL) && (sub != 2'b11) &&
                        !(func[1] && (sub == 2'b10));
  assign is_alu_imm   = (cls == CLS_ALU_IMM);
  assign is_br        = (cls == CLS_BRANCH) && (func != 2'b11);
  assign is_jal       = (cls == CLS_BRANCH_JUMP) && (func == 2'b00);
  assign is_ld        = (cls == CLS_DM_FUN) && (func == FUNC_LD);
  assign is_sd        = (cls == CLS_DM_FUN) && (func == FUNC_SD);
  assign is_shift_imm = is_cal && (func == FUNC_BIN_SHIFT_IMM);
  assign legal        = is_cal | is_alu_imm | is_br | is_jal | is_ld | is_sd;

  always_comb begin
    dec = '0;
    imm = '0;
    if (!legal) begin
      dec.illegal = 1'b1;
    end else begin
      dec.alu_op  = {inst[15:11], inst[1:0]};
      dec.addr_0  = (is_cal | is_alu_imm | is_br | is_ld | is_sd) ? rs0 : 3'd0;
      dec.addr_1  = ((is_cal && !is_shift_imm) | is_br | is_sd) ? rs1 : 3'd0;
      dec.w_addr  = (is_cal | is_alu_imm | is_jal | is_ld) ? rd : 3'd0;
      dec.rf_w_en = is_cal | is_alu_imm | is_jal | is_ld;
      dec.alusrc  = is_alu_imm | is_shift_imm;
      dec.branch  = is_br | is_jal;
      dec.mem2reg = is_ld;
      dec.dm_r_en = is_ld;
      dec.dm_w_en = is_sd;
      dec.is_jal  = is_jal;
      if (is_shift_imm) begin
        imm = {{(DATA_W-3){1'b0}}, inst[4:2]};
      end else if (is_alu_imm || is_ld) begin
        imm = {{(DATA_W-5){1'b0}}, inst[4:0]};
      end else if (is_br) begin
        imm = {{(DATA_W-5){inst[10]}}, inst[10:8], inst[1:0]};
      end else if (is_jal) begin
        imm = {{(DATA_W-8){inst[7]}}, inst[7:0]};
      end else if (is_sd) begin
        imm = {{(DATA_W-5){1'b0}}, inst[10:8], inst[1:0]};
      end
    end
  end

endmodule

// File: rtl/id_stage.sv
// Registered decode stage with valid/ready on both sides, load-use stall,
// flush on taken branch, and a saturating illegal-instruction counter.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int PC_W      = 8,
  parameter int ILL_CNT_W = 4,
  parameter int HAZARD_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 if_valid,
  output logic                 if_ready,
  input  logic [15:0]          if_inst,
  input  logic [PC_W-1:0]      if_pc,
  output logic                 ex_valid,
  input  logic                 ex_ready,
  output logic [PC_W-1:0]      ex_pc,
  output logic [2:0]           ex_addr_0,
  output logic [2:0]           ex_addr_1,
  output logic [2:0]           ex_w_addr,
  output logic [DATA_W-1:0]    ex_imm,
  output logic [6:0]           ex_alu_op,
  output logic                 ex_branch,
  output logic                 ex_mem2reg,
  output logic                 ex_alusrc,
  output logic                 ex_rf_w_en,
  output logic                 ex_dm_w_en,
  output logic                 ex_dm_r_en,
  output logic                 ex_is_jal,
  output logic                 ex_illegal,
  output logic [ILL_CNT_W-1:0] ill_count
);

  dec_t              dec_in;
  logic [DATA_W-1:0] imm_in;

  logic                 ex_valid_q, ex_valid_d;
  logic [PC_W-1:0]      ex_pc_q, ex_pc_d;
  dec_t                 dec_q, dec_d;
  logic [DATA_W-1:0]    imm_q, imm_d;
  logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;

  logic hazard;
  logic accept;

  id_stage_decode #(.DATA_W(DATA_W)) u_decode (
    .inst (if_inst),
    .dec  (dec_in),
    .imm  (imm_in)
  );

  // Unused source fields decode to 0 and w_addr is non-zero here, so they never match.
  assign hazard = (HAZARD_EN != 0) && ex_valid_q && dec_q.mem2reg &&
                  (dec_q.w_addr != 3'd0) &&
                  ((dec_in.addr_0 == dec_q.w_addr) || (dec_in.addr_1 == dec_q.w_addr));

  assign if_ready = !rst && (flush || ((!ex_valid_q || ex_ready) && !hazard));
  assign accept   = if_valid && if_ready;

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_pc_d    = ex_pc_q;
    dec_d      = dec_q;
    imm_d      = imm_q;
    ill_cnt_d  = ill_cnt_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (accept) begin
      ex_valid_d = 1'b1;
      ex_pc_d    = if_pc;
      dec_d      = dec_in;
      imm_d      = imm_in;
      if (dec_in.illegal && (ill_cnt_q != {ILL_CNT_W{1'b1}})) begin
        ill_cnt_d = ill_cnt_q + 1'b1;
      end
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_pc_q    <= '0;
      dec_q      <= '0;
      imm_q      <= '0;
      ill_cnt_q  <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_pc_q    <= ex_pc_d;
      dec_q      <= dec_d;
      imm_q      <= imm_d;
      ill_cnt_q  <= ill_cnt_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_pc      = ex_pc_q;
  assign ex_addr_0  = dec_q.addr_0;
  assign ex_addr_1  = dec_q.addr_1;
  assign ex_w_addr  = dec_q.w_addr;
  assign ex_imm     = imm_q;
  assign ex_alu_op  = dec_q.alu_op;
  assign ex_branch  = dec_q.branch;
  assign ex_mem2reg = dec_q.mem2reg;
  assign ex_alusrc  = dec_q.alusrc;
  assign ex_rf_w_en = dec_q.rf_w_en;
  assign ex_dm_w_en = dec_q.dm_w_en;
  assign ex_dm_r_en = dec_q.dm_r_en;
  assign ex_is_jal  = dec_q.is_jal;
  assign ex_illegal = dec_q.illegal;
  assign ill_count  = ill_cnt_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: instance a (DATA_W=8, stall enabled) and
// instance b (DATA_W=16, stall disabled) share one stimulus stream.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst, flush, if_valid, ex_ready;
  logic [15:0] if_inst;
  logic [7:0]  if_pc;

  logic        a_if_ready, a_ex_valid, a_branch, a_mem2reg, a_alusrc, a_rf_w_en;
  logic        a_dm_w_en, a_dm_r_en, a_is_jal, a_illegal;
  logic [7:0]  a_ex_pc, a_imm;
  logic [2:0]  a_addr_0, a_addr_1, a_w_addr;
  logic [6:0]  a_alu_op;
  logic [3:0]  a_ill;

  logic        b_if_ready, b_ex_valid, b_branch, b_mem2reg, b_alusrc, b_rf_w_en;
  logic        b_dm_w_en, b_dm_r_en, b_is_jal, b_illegal;
  logic [7:0]  b_ex_pc;
  logic [15:0] b_imm;
  logic [2:0]  b_addr_0, b_addr_1, b_w_addr;
  logic [6:0]  b_alu_op;
  logic [3:0]  b_ill;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_stage #(.DATA_W(8), .PC_W(8), .ILL_CNT_W(4), .HAZARD_EN(1)) u_dut_a (
    .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_ready(a_if_ready),
    .if_inst(if_inst), .if_pc(if_pc), .ex_valid(a_ex_valid), .ex_ready(ex_ready),
    .ex_pc(a_ex_pc), .ex_addr_0(a_addr_0), .ex_addr_1(a_addr_1), .ex_w_addr(a_w_addr),
    .ex_imm(a_imm), .ex_alu_op(a_alu_op), .ex_branch(a_branch), .ex_mem2reg(a_mem2reg),
    .ex_alusrc(a_alusrc), .ex_rf_w_en(a_rf_w_en), .ex_dm_w_en(a_dm_w_en),
    .ex_dm_r_en(a_dm_r_en), .ex_is_jal(a_is_jal), .ex_illegal(a_illegal), .ill_count(a_ill)
  );

  id_stage #(.DATA_W(16), .PC_W(8), .ILL_CNT_W(4), .HAZARD_EN(0)) u_dut_b (
    .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_ready(b_if_ready),
    .if_inst(if_inst), .if_pc(if_pc), .ex_valid(b_ex_valid), .ex_ready(ex_ready),
    .ex_pc(b_ex_pc), .ex_addr_0(b_addr_0), .ex_addr_1(b_addr_1), .ex_w_addr(b_w_addr),
    .ex_imm(b_imm), .ex_alu_op(b_alu_op), .ex_branch(b_branch), .ex_mem2reg(b_mem2reg),
    .ex_alusrc(b_alusrc), .ex_rf_w_en(b_rf_w_en), .ex_dm_w_en(b_dm_w_en),
    .ex_dm_r_en(b_dm_r_en), .ex_is_jal(b_is_jal), .ex_illegal(b_illegal), .ill_count(b_ill)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b0;
    if_inst = 16'h0000; if_pc = 8'h00;
    tick();
    tick();
    chk("rst_ex_valid", 32'(a_ex_valid), 32'd0);
    chk("rst_if_ready", 32'(a_if_ready), 32'd0);
    chk("rst_ill_count", 32'(a_ill), 32'd0);
    chk("rst_ex_pc", 32'(a_ex_pc), 32'd0);
    chk("rst_w_addr", 32'(a_w_addr), 32'd0);
    chk("rst_imm", 32'(a_imm), 32'd0);

    // LD r3 <- [r1+5], then ADD r2 = r3 op r4 back-to-back
    rst = 1'b0; ex_ready = 1'b1; if_valid = 1'b1; if_inst = 16'h8325; if_pc = 8'h10;
    #1 chk("ld_if_ready", 32'(a_if_ready), 32'd1);
    tick();
    chk("ld_valid", 32'(a_ex_valid), 32'd1);
    chk("ld_pc", 32'(a_ex_pc), 32'h10);
    chk("ld_w_addr", 32'(a_w_addr), 32'd3);
    chk("ld_addr_0", 32'(a_addr_0), 32'd1);
    chk("ld_addr_1", 32'(a_addr_1), 32'd0);
    chk("ld_imm", 32'(a_imm), 32'd5);
    chk("ld_mem2reg", 32'(a_mem2reg), 32'd1);
    chk("ld_dm_r_en", 32'(a_dm_r_en), 32'd1);
    chk("ld_rf_w_en", 32'(a_rf_w_en), 32'd1);
    chk("ld_alusrc", 32'(a_alusrc), 32'd0);
    if_inst = 16'h0270; if_pc = 8'h11;
    #1 chk("hz_if_ready_a", 32'(a_if_ready), 32'd0);
    chk("hz_if_ready_b", 32'(b_if_ready), 32'd1);
    tick();
    chk("hz_bubble_a", 32'(a_ex_valid), 32'd0);
    chk("nohz_valid_b", 32'(b_ex_valid), 32'd1);
    chk("nohz_addr_0_b", 32'(b_addr_0), 32'd3);
    chk("hz_release_ready", 32'(a_if_ready), 32'd1);
    tick();
    chk("add_valid", 32'(a_ex_valid), 32'd1);
    chk("add_pc", 32'(a_ex_pc), 32'h11);
    chk("add_addr_0", 32'(a_addr_0), 32'd3);
    chk("add_addr_1", 32'(a_addr_1), 32'd4);
    chk("add_w_addr", 32'(a_w_addr), 32'd2);
    chk("add_alu_op", 32'(a_alu_op), 32'h00);
    chk("add_mem2reg", 32'(a_mem2reg), 32'd0);
    if_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(a_ex_valid), 32'd0);

    // BRANCH 0x472A: imm = sext(5'b11110)
    if_valid = 1'b1; if_inst = 16'h472A; if_pc = 8'h20;
    tick();
    if_valid = 1'b0;
    chk("br_imm_8", 32'(a_imm), 32'hFE);
    chk("br_imm_16", 32'(b_imm), 32'hFFFE);
    chk("br_branch", 32'(a_branch), 32'd1);
    chk("br_addr_0", 32'(a_addr_0), 32'd1);
    chk("br_addr_1", 32'(a_addr_1), 32'd2);
    chk("br_w_addr", 32'(a_w_addr), 32'd0);
    chk("br_rf_w_en", 32'(a_rf_w_en), 32'd0);
    tick();

    // Back-pressure: ADD held for 5 cycles while ALU_IMM 0x255F waits
    ex_ready = 1'b0; if_valid = 1'b1; if_inst = 16'h0270; if_pc = 8'h30;
    tick();
    chk("stall_first_valid", 32'(a_ex_valid), 32'd1);
    if_inst = 16'h255F; if_pc = 8'h31;
    for (int i = 0; i < 5; i++) begin
      #1 chk("stall_if_ready", 32'(a_if_ready), 32'd0);
      tick();
      chk("stall_hold_pc", 32'(a_ex_pc), 32'h30);
      chk("stall_hold_w", 32'(a_w_addr), 32'd2);
      chk("stall_hold_valid", 32'(a_ex_valid), 32'd1);
    end
    ex_ready = 1'b1;
    #1 chk("stall_release_ready", 32'(a_if_ready), 32'd1);
    tick();
    chk("imm_pc", 32'(a_ex_pc), 32'h31);
    chk("imm_imm", 32'(a_imm), 32'h1F);
    chk("imm_alusrc", 32'(a_alusrc), 32'd1);
    chk("imm_w_addr", 32'(a_w_addr), 32'd5);
    chk("imm_addr_0", 32'(a_addr_0), 32'd2);
    chk("imm_alu_op", 32'(a_alu_op), 32'h13);

    // Flush overrides back-pressure and discards an illegal word without counting it
    ex_ready = 1'b0; flush = 1'b1; if_inst = 16'hE000; if_pc = 8'h40;
    #1 chk("flush_if_ready", 32'(a_if_ready), 32'd1);
    tick();
    flush = 1'b0; if_valid = 1'b0;
    chk("flush_valid", 32'(a_ex_valid), 32'd0);
    chk("flush_ill_count", 32'(a_ill), 32'd0);

    // 20 illegal words: counter saturates at 15
    ex_ready = 1'b1; if_valid = 1'b1; if_inst = 16'hE000;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("ill_count", 32'(a_ill), (i < 15) ? 32'(i + 1) : 32'd15);
    end
    if_valid = 1'b0;
    chk("ill_flag", 32'(a_illegal), 32'd1);
    chk("ill_valid", 32'(a_ex_valid), 32'd1);
    chk("ill_rf_w_en", 32'(a_rf_w_en), 32'd0);
    chk("ill_w_addr", 32'(a_w_addr), 32'd0);
    chk("ill_imm", 32'(a_imm), 32'd0);
    chk("ill_branch", 32'(a_branch), 32'd0);
    tick();

    // Reset during a load-use stall drops the held word
    ex_ready = 1'b0; if_valid = 1'b1; if_inst = 16'h8325; if_pc = 8'h50;
    tick();
    if_inst = 16'h0270; if_pc = 8'h51;
    #1 chk("rst_stall_ready", 32'(a_if_ready), 32'd0);
    rst = 1'b1;
    #1 chk("rst_in_if_ready", 32'(a_if_ready), 32'd0);
    tick();
    chk("rst2_valid", 32'(a_ex_valid), 32'd0);
    chk("rst2_pc", 32'(a_ex_pc), 32'd0);
    chk("rst2_w_addr", 32'(a_w_addr), 32'd0);
    chk("rst2_mem2reg", 32'(a_mem2reg), 32'd0);
    chk("rst2_ill_count", 32'(a_ill), 32'd0);
    chk("rst2_if_ready", 32'(a_if_ready), 32'd0);
    rst = 1'b0; ex_ready = 1'b1; if_valid = 1'b0;
    tick();
    chk("rst2_no_replay", 32'(a_ex_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
